vedic_seq_mult: RTL and testbench



---
 rtl/vedic_pkg.sv | 13 +
 rtl/vedic_2x2.sv | 21 ++
 rtl/vedic_seq_mult.sv | 98 +++++++++
 tb/tb_vedic_seq_mult.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared constants and helpers for the iterative vedic multiplier.
// FSM state encoding and digit-count function.
package vedic_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int digits(input int w);
    return w / 2;
  endfunction

endpackage

// File: rtl/vedic_2x2.sv
// Two-bit by two-bit vedic (urdhva-tiryak) multiplier cell.
// Purely combinational, 4-bit unsigned product.
module vedic_2x2 (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [3:0] p
);

  logic v, c;

  // vertical and crosswise partial products with ripple carry
  always_comb begin
    v    = x[1] & y[1];
    c    = x[1] & y[0] & x[0] & y[1];
    p[0] = x[0] & y[0];
    p[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    p[2] = v ^ c;
    p[3] = v & c;
  end

endmodule

// File: rtl/vedic_seq_mult.sv
// Iterative WIDTH x WIDTH unsigned multiplier built on one vedic_2x2.
// One digit pair per cycle, shifted and accumulated into 2*WIDTH bits.
module vedic_seq_mult
  import vedic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int N  = digits(WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [PW-1:0]    acc;
  logic [IW-1:0]    i, j;

  logic [1:0]       da, db;
  logic [3:0]       pp;
  logic [IW:0]      sh;
  logic [PW-1:0]    term;
  logic [PW-1:0]    sum;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // digit selection and weighted partial product
  always_comb begin
    da   = 2'(a_reg >> {i, 1'b0});
    db   = 2'(b_reg >> {j, 1'b0});
    sh   = {1'b0, i} + {1'b0, j};
    term = PW'(pp) << {sh, 1'b0};
    sum  = acc + term;
  end

  vedic_2x2 u_cell (
    .x (da),
    .y (db),
    .p (pp)
  );

  // control FSM, index counters, accumulator and output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      i       <= '0;
      j       <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= sum;
          if (j == LAST) begin
            j <= '0;
            if (i == LAST) begin
              i       <= '0;
              product <= sum;
              state   <= DONE;
            end else begin
              i <= i + 1'b1;
            end
          end else begin
            j <= j + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_seq_mult.sv
// Self-checking bench for vedic_seq_mult (WIDTH=8 and WIDTH=2).
// Reference is plain integer multiplication.
module tb_vedic_seq_mult;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0, b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] product;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [1:0]  a2 = '0, b2 = '0;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;
  logic [3:0]  product2;

  int tests = 0;
  int fails = 0;
  logic [15:0] expv;

  always #5 clk = ~clk;

  vedic_seq_mult #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  vedic_seq_mult #(.WIDTH(2)) dut2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .a         (a2),
    .b         (b2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .product   (product2)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // wait for in_ready, present operands, leave in_valid low afterwards
  task automatic start(input logic [7:0] x, input logic [7:0] y);
    int k = 0;
    while (!in_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("ready_before_accept", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    a = x;
    b = y;
    in_valid = 1'b1;
    expv = 16'(x) * 16'(y);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // count edges to out_valid, hold for bp cycles, then handshake
  task automatic finish(input int bp);
    int  cnt = 0;
    bit  rdy_low = 1'b1;
    do begin
      @(posedge clk); #1;
      cnt++;
      if (in_ready) rdy_low = 1'b0;
    end while (!out_valid && cnt < 100);
    check("latency", 64'(cnt), 64'd16);
    check("ready_low_busy", {63'd0, rdy_low}, 64'd1);
    check("product", 64'(product), 64'(expv));
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      check("bp_valid", {63'd0, out_valid}, 64'd1);
      check("bp_ready", {63'd0, in_ready}, 64'd0);
      check("bp_product", 64'(product), 64'(expv));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_pulse_end", {63'd0, out_valid}, 64'd0);
    check("ready_after_hs", {63'd0, in_ready}, 64'd1);
    check("product_kept", 64'(product), 64'(expv));
  endtask

  initial begin
    #12;
    check("rst_ready", {63'd0, in_ready}, 64'd1);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_product", 64'(product), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    start(8'hFF, 8'hFF);
    check("const_ff", 64'(expv), 64'hFE01);
    finish(0);

    start(8'h00, 8'hA5);
    finish(0);
    start(8'h12, 8'h34);
    check("const_1234", 64'(expv), 64'h03A8);
    finish(0);

    // second pair held during RUN must not disturb the first
    start(8'h03, 8'h05);
    in_valid = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    finish(0);
    check("hold_first", 64'(product), 64'h000F);
    expv = 16'hFE01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("hold_accepted", {63'd0, in_ready}, 64'd0);
    finish(0);

    // back-pressure
    start(8'h9C, 8'h37);
    out_ready = 1'b0;
    finish(5);

    // reset mid-RUN
    start(8'h55, 8'h66);
    repeat (6) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_product", 64'(product), 64'd0);
    check("mid_rst_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    start(8'h12, 8'h34);
    finish(0);

    // randomized operands
    for (int n = 0; n < 20; n++) begin
      start(8'($urandom), 8'($urandom));
      out_ready = 1'($urandom);
      finish(out_ready ? 0 : int'($urandom_range(1, 3)));
    end

    // WIDTH=2 instance: all operand pairs, one-edge latency
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        @(negedge clk);
        check("w2_ready", {63'd0, in_ready2}, 64'd1);
        a2 = 2'(x);
        b2 = 2'(y);
        in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        check("w2_not_yet", {63'd0, out_valid2}, 64'd0);
        @(posedge clk); #1;
        check("w2_valid", {63'd0, out_valid2}, 64'd1);
        check("w2_product", 64'(product2), 64'(x * y));
        @(posedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
